isqrt_arbiter: RTL

ISQRT_ARBITER -- requirements
Module: isqrt_arbiter

---
 rtl/isqrt_arbiter_if.sv | 27 ++
 rtl/isqrt_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/isqrt_arbiter_if.sv
// Requester and pipeline signal bundle for isqrt_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface isqrt_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] req_x;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rsp_valid;
    logic [15:0]         rsp_y;
    logic [N_REQ-1:0]    busy;
    logic                tag_err;
    logic                pipe_run;
    logic [31:0]         pipe_x;
    logic                pipe_ready;
    logic [15:0]         pipe_y;

    modport slave (
        input  req, req_x, pipe_ready, pipe_y,
        output gnt, rsp_valid, rsp_y, busy, tag_err, pipe_run, pipe_x
    );

    modport master (
        output req, req_x, pipe_ready, pipe_y,
        input  gnt, rsp_valid, rsp_y, busy, tag_err, pipe_run, pipe_x
    );
endinterface

// File: rtl/isqrt_arbiter.sv
// Round-robin arbiter sharing one fixed-latency square-root pipeline among N_REQ requesters.
// Issue tags ride a shift register so each pipe_ready is routed back to its requester.
module isqrt_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LATENCY = 8
) (
    input logic            clock,
    input logic            reset,
    isqrt_arbiter_if.slave bus
);
    localparam int unsigned   IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned   TW       = IW + 1;
    localparam int unsigned   TAGW     = TW * LATENCY;
    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0] busy_q, busy_d;
    logic [15:0]      rsp_y_q, rsp_y_d;
    logic             tag_err_q, tag_err_d;
    logic             pipe_run_q, pipe_run_d;
    logic [31:0]      pipe_x_q, pipe_x_d;
    logic [IW-1:0]    last_grant_q, last_grant_d;
    logic [TAGW-1:0]  tag_q, tag_d;

    logic [31:0]      x_arr [N_REQ];
    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [IW-1:0]    winner;
    logic [IW-1:0]    cand;
    logic             tail_v;
    logic [IW-1:0]    tail_idx;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign x_arr[g] = bus.req_x[32*g +: 32];
    end

    // Registered busy masks eligibility, so a requester cannot be regranted on its rsp_valid edge.
    assign eligible = bus.req & ~busy_q;
    assign tail_v   = tag_q[TAGW-1];
    assign tail_idx = tag_q[TAGW-2 -: IW];

    always_comb begin : arbitrate
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IW'((32'(last_grant_q) + k) % N_REQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin : next_state
        gnt_d        = '0;
        pipe_run_d   = 1'b0;
        pipe_x_d     = pipe_x_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = '0;
        rsp_y_d      = rsp_y_q;
        busy_d       = busy_q;
        tag_err_d    = tag_err_q;
        // New entry enters at the LSBs; the oldest (tail) entry falls off the top.
        tag_d        = TAGW'({tag_q, pipe_run_q, last_grant_q});

        if (bus.pipe_ready && tail_v) begin
            rsp_valid_d = N_REQ'(1) << tail_idx;
            rsp_y_d     = bus.pipe_y;
            busy_d      = busy_d & ~rsp_valid_d;
        end
        if (bus.pipe_ready != tail_v) begin
            tag_err_d = 1'b1;
        end

        if (found) begin
            gnt_d        = N_REQ'(1) << winner;
            pipe_run_d   = 1'b1;
            pipe_x_d     = x_arr[winner];
            last_grant_d = winner;
            busy_d       = busy_d | gnt_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            busy_q       <= '0;
            rsp_y_q      <= '0;
            tag_err_q    <= 1'b0;
            pipe_run_q   <= 1'b0;
            pipe_x_q     <= '0;
            last_grant_q <= LAST_RST;
            tag_q        <= '0;
        end else begin
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            rsp_y_q      <= rsp_y_d;
            tag_err_q    <= tag_err_d;
            pipe_run_q   <= pipe_run_d;
            pipe_x_q     <= pipe_x_d;
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.tag_err   = tag_err_q;
    assign bus.pipe_run  = pipe_run_q;
    assign bus.pipe_x    = pipe_x_q;
endmodule
